// File: rtl/link_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack link among N_REQ masters; optional watchdog via LINK_ARB_TIMEOUT_EN.
// Latency: grant one cycle after a request is sampled; req/data/ack are muxed combinationally from the registered winner.
// Backpressure: non-winners see no ack until the owner's handshake fully closes and the arbiter passes through IDLE.
module link_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        m_req,
  input  logic [N_REQ*DATA_W-1:0] m_data,
  output logic [N_REQ-1:0]        m_ack,
  output logic                    s_req,
  output logic [DATA_W-1:0]       s_data,
  input  logic                    s_ack,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    timeout
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ACKED = 2'd2
  } state_e;

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
    $error("link_arbiter: N_REQ must be in 2..8");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("link_arbiter: TIMEOUT must be at least 2");
  end

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [PW-1:0]      win_q, win_d;
  logic [PW-1:0]      pick;
  logic               any_req;
  logic [PW-1:0]      win_inc;
  logic [PW:0]        cand;
  logic [DATA_W-1:0]  data_arr [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      data_arr[i] = m_data[i*DATA_W +: DATA_W];
    end
  end

  // Walk downward so the lowest offset from ptr (highest priority) is written last.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, ptr_q} + (PW + 1)'(i);
      if (cand >= (PW + 1)'(N_REQ)) begin
        cand = cand - (PW + 1)'(N_REQ);
      end
      if (m_req[PW'(cand)]) begin
        pick    = PW'(cand);
        any_req = 1'b1;
      end
    end
  end

  assign win_inc = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + 1'b1;

`ifdef LINK_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wdog_q, wdog_d;
  logic          timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
`ifdef LINK_ARB_TIMEOUT_EN
    wdog_d    = wdog_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef LINK_ARB_TIMEOUT_EN
        wdog_d = '0;
`endif
        if (any_req) begin
          win_d   = pick;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (s_ack) begin
          state_d = ACKED;
        end else if (!m_req[win_q]) begin
          // Withdrawn before ack: ptr stays so this master keeps priority.
          state_d = IDLE;
`ifdef LINK_ARB_TIMEOUT_EN
        end else if (wdog_q == CW'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          ptr_d     = win_inc;
          timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
`endif
        end
      end
      ACKED: begin
        if (!m_req[win_q] && !s_ack) begin
          ptr_d   = win_inc;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
    end
  end

`ifdef LINK_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign busy = (state_q != IDLE);

  always_comb begin
    s_req  = 1'b0;
    s_data = '0;
    m_ack  = '0;
    grant  = '0;
    if (state_q != IDLE) begin
      s_req        = m_req[win_q];
      s_data       = data_arr[win_q];
      m_ack[win_q] = s_ack;
      grant[win_q] = 1'b1;
    end
  end

endmodule

// File: tb/tb_link_arbiter.sv
// Directed bench for link_arbiter: vector table for single/contended/withdrawn transfers, then reset, fairness and watchdog sequences.
module tb_link_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  m_req;
  logic [31:0] m_data;
  logic [3:0]  m_ack;
  logic        s_req;
  logic [7:0]  s_data;
  logic        s_ack;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic       ack;
    logic [3:0] grant;
    logic       busy;
    logic       sreq;
    logic [7:0] sdata;
    logic [3:0] mack;
  } vec_t;

  vec_t vecs[$];

  link_arbiter #(
    .N_REQ  (4),
    .DATA_W (8),
    .TIMEOUT(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .m_req  (m_req),
    .m_data (m_data),
    .m_ack  (m_ack),
    .s_req  (s_req),
    .s_data (s_data),
    .s_ack  (s_ack),
    .grant  (grant),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] r, input logic a, input logic [3:0] g,
                              input logic b, input logic sr, input logic [7:0] sd,
                              input logic [3:0] ma);
    vec_t v;
    v.req = r; v.ack = a; v.grant = g; v.busy = b; v.sreq = sr; v.sdata = sd; v.mack = ma;
    return v;
  endfunction

  initial begin
    logic [3:0] onehot;
    logic [7:0] exp_data;

    // req, ack | grant, busy, s_req, s_data, m_ack
    vecs.push_back(mk(4'b0001, 0, 4'b0000, 0, 0, 8'h00, 4'b0000));
    vecs.push_back(mk(4'b0001, 0, 4'b0001, 1, 1, 8'hA0, 4'b0000));
    vecs.push_back(mk(4'b0001, 0, 4'b0001, 1, 1, 8'hA0, 4'b0000));
    vecs.push_back(mk(4'b0001, 1, 4'b0001, 1, 1, 8'hA0, 4'b0001));
    vecs.push_back(mk(4'b0000, 1, 4'b0001, 1, 0, 8'hA0, 4'b0001));
    vecs.push_back(mk(4'b0000, 0, 4'b0001, 1, 0, 8'hA0, 4'b0000));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 8'h00, 4'b0000));
    vecs.push_back(mk(4'b1010, 0, 4'b0000, 0, 0, 8'h00, 4'b0000));
    vecs.push_back(mk(4'b1010, 0, 4'b0010, 1, 1, 8'hA1, 4'b0000));
    vecs.push_back(mk(4'b1010, 1, 4'b0010, 1, 1, 8'hA1, 4'b0010));
    vecs.push_back(mk(4'b1000, 1, 4'b0010, 1, 0, 8'hA1, 4'b0010));
    vecs.push_back(mk(4'b1000, 0, 4'b0010, 1, 0, 8'hA1, 4'b0000));
    vecs.push_back(mk(4'b1000, 0, 4'b0000, 0, 0, 8'h00, 4'b0000));
    vecs.push_back(mk(4'b1000, 0, 4'b1000, 1, 1, 8'hA3, 4'b0000));
    vecs.push_back(mk(4'b1000, 1, 4'b1000, 1, 1, 8'hA3, 4'b1000));
    vecs.push_back(mk(4'b0000, 0, 4'b1000, 1, 0, 8'hA3, 4'b0000));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 8'h00, 4'b0000));
    vecs.push_back(mk(4'b0100, 0, 4'b0000, 0, 0, 8'h00, 4'b0000));
    vecs.push_back(mk(4'b0000, 0, 4'b0100, 1, 0, 8'hA2, 4'b0000));
    vecs.push_back(mk(4'b1100, 0, 4'b0000, 0, 0, 8'h00, 4'b0000));
    vecs.push_back(mk(4'b1100, 0, 4'b0100, 1, 1, 8'hA2, 4'b0000));
    vecs.push_back(mk(4'b1000, 1, 4'b0100, 1, 0, 8'hA2, 4'b0100));
    vecs.push_back(mk(4'b1000, 0, 4'b0100, 1, 0, 8'hA2, 4'b0000));
    vecs.push_back(mk(4'b1000, 0, 4'b0000, 0, 0, 8'h00, 4'b0000));
    vecs.push_back(mk(4'b1000, 0, 4'b1000, 1, 1, 8'hA3, 4'b0000));
    vecs.push_back(mk(4'b0000, 0, 4'b1000, 1, 0, 8'hA3, 4'b0000));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 8'h00, 4'b0000));
    vecs.push_back(mk(4'b0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000));
    vecs.push_back(mk(4'b0000, 0, 4'b0000, 0, 0, 8'h00, 4'b0000));

    // Reset held with live inputs: outputs must stay quiet.
    rst    = 1'b0;
    m_req  = 4'b1111;
    m_data = 32'hA3A2A1A0;
    s_ack  = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_s_req", 32'(s_req), 32'h0);
    chk("rst_s_data", 32'(s_data), 32'h0);
    chk("rst_m_ack", 32'(m_ack), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    @(negedge clk);
    m_req = 4'b0000;
    s_ack = 1'b0;
    rst   = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      m_req = vecs[i].req;
      s_ack = vecs[i].ack;
      #1;
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].grant));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("v%0d_s_req", i), 32'(s_req), 32'(vecs[i].sreq));
      chk($sformatf("v%0d_s_data", i), 32'(s_data), 32'(vecs[i].sdata));
      chk($sformatf("v%0d_m_ack", i), 32'(m_ack), 32'(vecs[i].mack));
      chk($sformatf("v%0d_timeout", i), 32'(timeout), 32'h0);
    end

    // Async reset while ACKED with s_req high.
    @(negedge clk);
    m_req = 4'b0010;
    s_ack = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_grant", 32'(grant), 32'h2);
    s_ack = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_acked_s_req", 32'(s_req), 32'h1);
    chk("mid_acked_m_ack", 32'(m_ack), 32'h2);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_s_req", 32'(s_req), 32'h0);
    chk("arst_grant", 32'(grant), 32'h0);
    chk("arst_m_ack", 32'(m_ack), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_s_data", 32'(s_data), 32'h0);
    @(negedge clk);
    m_req = 4'b0000;
    s_ack = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 32'h0);

    // Fairness from ptr=0 with everyone requesting.
    m_req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      onehot   = 4'b0001 << (k % 4);
      exp_data = 8'hA0 + 8'(k % 4);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d_grant", k), 32'(grant), 32'(onehot));
      chk($sformatf("rr%0d_s_data", k), 32'(s_data), 32'(exp_data));
      chk($sformatf("rr%0d_m_ack_pre", k), 32'(m_ack), 32'h0);
      s_ack = 1'b1;
      #1;
      chk($sformatf("rr%0d_m_ack", k), 32'(m_ack), 32'(onehot));
      @(negedge clk);
      m_req = 4'b1111 & ~onehot;
      s_ack = 1'b0;
      #1;
      chk($sformatf("rr%0d_acked_busy", k), 32'(busy), 32'h1);
      chk($sformatf("rr%0d_acked_m_ack", k), 32'(m_ack), 32'h0);
      @(negedge clk);
      #1;
      chk($sformatf("rr%0d_idle_busy", k), 32'(busy), 32'h0);
      m_req = 4'b1111;
    end
    @(negedge clk);
    m_req = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rr_end_busy", 32'(busy), 32'h0);

`ifdef LINK_ARB_TIMEOUT_EN
    // Master 0 stuck without ack; master 1 waiting.
    m_req = 4'b0011;
    @(negedge clk);
    #1;
    chk("wd_grant_first", 32'(grant), 32'h1);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("wd%0d_grant", c), 32'(grant), 32'h1);
      chk($sformatf("wd%0d_timeout", c), 32'(timeout), 32'h0);
    end
    @(negedge clk);
    #1;
    chk("wd_fire_timeout", 32'(timeout), 32'h1);
    chk("wd_fire_grant", 32'(grant), 32'h0);
    @(negedge clk);
    #1;
    chk("wd_after_timeout", 32'(timeout), 32'h0);
    chk("wd_next_grant", 32'(grant), 32'h2);
    m_req = 4'b0000;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
